// File: rtl/seq_det_ctrl.sv
// Configurable serial pattern detector (1..8 bits, MSB received first) with arm/disarm control.
// Define SEQ_DET_CTRL_NONOVERLAP_EN to stop the bits of a reported match from being reused.
module seq_det_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       in_valid,
  input  logic       cfg_valid,
  input  logic [7:0] cfg_pattern,
  input  logic [2:0] cfg_len,
  output logic       cfg_ready,
  input  logic       arm,
  input  logic       disarm,
  output logic       out,
  output logic       busy,
  output logic [7:0] match_count
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned FILL_W = 4;
  localparam int unsigned LEN_W  = 3;

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   shift_q, pattern_q, shift_new, mask;
  logic [FILL_W-1:0]   fill_q, fill_new, len_full;
  logic [LEN_W-1:0]    len_q;
  logic                sample, hit, match;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; disarm has priority over arm
  always_comb begin
    state_next = state;
    if (state == IDLE) begin
      if (arm && !disarm) state_next = ARMED;
    end else begin
      if (disarm) state_next = IDLE;
    end
  end

  // State-decoded outputs
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    if (state == IDLE) cfg_ready = 1'b1;
    else               busy      = 1'b1;
  end

  // Match evaluation includes the bit being sampled on this edge
  always_comb begin
    shift_new = {shift_q[DATA_W-2:0], in};
    fill_new  = (fill_q == FILL_W'(DATA_W)) ? fill_q : fill_q + FILL_W'(1);
    len_full  = FILL_W'(len_q) + FILL_W'(1);
    mask      = 8'hFF >> (LEN_W'(DATA_W - 1) - len_q);
    sample    = (state == ARMED) && in_valid && !disarm;
    hit       = (fill_new >= len_full) && ((shift_new & mask) == (pattern_q & mask));
    match     = sample && hit;
  end

  // Datapath: configuration latch, shift register, fill counter, match pulse and count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out         <= 1'b0;
      match_count <= 8'd0;
      shift_q     <= 8'd0;
      fill_q      <= 4'd0;
      pattern_q   <= 8'h0B;
      len_q       <= 3'd3;
    end else begin
      out <= match;
      if (state == IDLE) begin
        if (cfg_valid) begin
          pattern_q <= cfg_pattern;
          len_q     <= cfg_len;
        end
        if (arm && !disarm) begin
          shift_q     <= 8'd0;
          fill_q      <= 4'd0;
          match_count <= 8'd0;
        end
      end else if (sample) begin
        shift_q <= shift_new;
`ifdef SEQ_DET_CTRL_NONOVERLAP_EN
        fill_q  <= match ? 4'd0 : fill_new;
`else
        fill_q  <= fill_new;
`endif
        if (match && (match_count != 8'hFF)) match_count <= match_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed self-checking bench for seq_det_ctrl with hand-computed expectations.
module tb_seq_det_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in, in_valid, cfg_valid, arm, disarm;
  logic [7:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       cfg_ready, out, busy;
  logic [7:0] match_count;

  int n_total = 0;
  int n_pass  = 0;

  seq_det_ctrl dut (
    .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
    .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_ready(cfg_ready), .arm(arm), .disarm(disarm), .out(out),
    .busy(busy), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic exp_out, input string tag);
    in = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check(tag, 32'(out), 32'(exp_out));
  endtask

  task automatic cfg_arm(input logic [7:0] pat, input logic [2:0] len);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_valid   = 1'b1;
    arm         = 1'b1;
    step();
    cfg_valid   = 1'b0;
    arm         = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    step();
    disarm = 1'b0;
  endtask

  logic [3:0] seq4;
  logic [6:0] seq7;
  logic [6:0] exp7;
  int         exp_mc7;

  initial begin
    reset = 1'b1; in = 1'b0; in_valid = 1'b0; cfg_valid = 1'b0;
    cfg_pattern = 8'h00; cfg_len = 3'd0; arm = 1'b0; disarm = 1'b0;
    seq4 = 4'b1011;
    seq7 = 7'b1011011;
`ifdef SEQ_DET_CTRL_NONOVERLAP_EN
    exp7 = 7'b0001000; exp_mc7 = 1;
`else
    exp7 = 7'b0001001; exp_mc7 = 2;
`endif

    // Reset state
    #3;
    check("rst_out", 32'(out), 32'd0);
    check("rst_mc", 32'(match_count), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    step();
    check("idle_cfg_ready", 32'(cfg_ready), 32'd1);

    // Default configuration 1011
    do_arm();
    check("arm_busy", 32'(busy), 32'd1);
    check("arm_cfg_ready", 32'(cfg_ready), 32'd0);
    check("arm_mc", 32'(match_count), 32'd0);
    for (int i = 0; i < 4; i++) send(seq4[3-i], (i == 3), $sformatf("dflt_bit%0d", i + 1));
    check("dflt_mc", 32'(match_count), 32'd1);
    step();
    check("dflt_out_clear", 32'(out), 32'd0);
    do_disarm();
    check("disarm_busy", 32'(busy), 32'd0);
    check("disarm_mc_hold", 32'(match_count), 32'd1);

    // Overlap behaviour, cfg and arm on the same edge
    cfg_arm(8'h0B, 3'd3);
    check("cfgarm_busy", 32'(busy), 32'd1);
    check("cfgarm_mc", 32'(match_count), 32'd0);
    for (int i = 0; i < 7; i++) send(seq7[6-i], exp7[6-i], $sformatf("ovl_bit%0d", i + 1));
    check("ovl_mc", 32'(match_count), 32'(exp_mc7));
    do_disarm();

    // Length 2 on a long run of ones: saturation of match_count
    cfg_arm(8'h03, 3'd1);
    for (int i = 0; i < 300; i++) begin
`ifdef SEQ_DET_CTRL_NONOVERLAP_EN
      send(1'b1, (i % 2 == 1), $sformatf("sat_bit%0d", i + 1));
`else
      send(1'b1, (i >= 1), $sformatf("sat_bit%0d", i + 1));
`endif
    end
`ifdef SEQ_DET_CTRL_NONOVERLAP_EN
    check("sat_mc", 32'(match_count), 32'd150);
`else
    check("sat_mc", 32'(match_count), 32'd255);
`endif
    do_disarm();
    check("sat_idle_out", 32'(out), 32'd0);

    // in_valid gaps with in toggling must not disturb detection
    cfg_arm(8'h0B, 3'd3);
    for (int i = 0; i < 4; i++) begin
      send(seq4[3-i], (i == 3), $sformatf("gap_bit%0d", i + 1));
      for (int g = 0; g < 2; g++) begin
        in = ~seq4[3-i];
        step();
        check($sformatf("gap_after%0d_%0d", i + 1, g), 32'(out), 32'd0);
      end
    end
    check("gap_mc", 32'(match_count), 32'd1);

    // Configuration offer while armed is refused
    cfg_pattern = 8'hFF; cfg_len = 3'd7; cfg_valid = 1'b1;
    #1;
    check("armed_cfg_ready", 32'(cfg_ready), 32'd0);
    step();
    cfg_valid = 1'b0;
    check("armed_cfg_ready2", 32'(cfg_ready), 32'd0);
    for (int i = 0; i < 4; i++) send(seq4[3-i], (i == 3), $sformatf("keep_bit%0d", i + 1));
    check("keep_mc", 32'(match_count), 32'd2);

    // disarm beats arm, both in ARMED and in IDLE
    arm = 1'b1; disarm = 1'b1;
    step();
    check("both_busy", 32'(busy), 32'd0);
    check("both_out", 32'(out), 32'd0);
    check("both_mc", 32'(match_count), 32'd2);
    step();
    arm = 1'b0; disarm = 1'b0;
    check("both_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a detection
    do_arm();
    for (int i = 0; i < 3; i++) send(seq4[3-i], 1'b0, $sformatf("mid_bit%0d", i + 1));
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("mid_rst_mc", 32'(match_count), 32'd0);
    in = 1'b1; in_valid = 1'b1;
    step();
    check("mid_rst_out", 32'(out), 32'd0);
    reset = 1'b0;
    step();
    in_valid = 1'b0;
    check("post_rst_out", 32'(out), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    do_arm();
    for (int i = 0; i < 4; i++) send(seq4[3-i], (i == 3), $sformatf("rearm_bit%0d", i + 1));
    check("rearm_mc", 32'(match_count), 32'd1);
    step();
    check("rearm_out_clear", 32'(out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in, input, 1 bit: serial data bit.
REQ-004 SHALL have port in_valid, input, 1 bit: in is sampled on this edge.
REQ-005 SHALL have port cfg_valid, input, 1 bit: configuration offer.
REQ-006 SHALL have port cfg_pattern, input, 8 bits: pattern; bit len-1 is received first, bit 0 last.
REQ-007 SHALL have port cfg_len, input, 3 bits: pattern length minus 1, giving a length of 1..8.
REQ-008 SHALL have port cfg_ready, output, 1 bit: configuration accept.
REQ-009 SHALL have port arm, input, 1 bit: start detection.
REQ-010 SHALL have port disarm, input, 1 bit: stop detection.
REQ-011 SHALL have port out, output, 1 bit: match pulse.
REQ-012 SHALL have port busy, output, 1 bit: high when the state is ARMED.
REQ-013 SHALL have port match_count, output, 8 bits: matches counted since the last arm.

Function
REQ-014 SHALL implement two states: IDLE and ARMED.
REQ-015 SHALL drive cfg_ready=1 only in IDLE.
REQ-016 SHALL latch cfg_pattern and cfg_len on an edge where cfg_valid && cfg_ready; the handshake completes that cycle.
REQ-017 SHALL ignore cfg_valid in ARMED and keep the latched configuration unchanged.
REQ-018 SHALL move IDLE->ARMED on arm=1 and, on that edge, clear the shift register, the fill counter and match_count.
REQ-019 SHALL let a cfg handshake and arm on the same IDLE edge take effect together, using the new configuration from the first sampled bit.
REQ-020 SHALL move ARMED->IDLE on disarm=1; disarm wins over arm when both are high.
REQ-021 SHALL hold match_count in IDLE after a disarm.
REQ-022 SHALL, in ARMED on each edge with in_valid=1, shift in into the LSB of an 8-bit shift register and increment the fill counter, saturating at 8.
REQ-023 SHALL leave the shift register, fill counter and out unchanged by edges with in_valid=0, except that out still returns to 0 on that edge.
REQ-024 SHALL declare a match on a sampling edge when the fill counter, including the new bit, is at least len and the low len bits of the shift register, including the new bit, equal the low len bits of the latched pattern.
REQ-025 SHALL register out=1 on the matching edge, so out is high for exactly the one cycle after it; consecutive matches give consecutive high cycles.
REQ-026 SHALL increment match_count on each match, saturating at 255 with no wrap.
REQ-027 SHALL drive out=0 whenever the state is IDLE; a disarm edge forces out=0 and discards any match on that edge.
REQ-028 SHALL ignore pattern bits above len-1.

Reset
REQ-029 SHALL, while reset=1 and independent of clk, force state=IDLE, out=0, match_count=0, shift register=0, fill counter=0, latched pattern=8'h0B and latched length=4.
REQ-030 SHALL force the outputs cfg_ready=1 and busy=0 during reset.
REQ-031 SHALL, when reset is asserted mid-detection, abandon the detection with no out pulse, and SHALL resume normal operation on the first edge after reset deasserts.

Configuration
REQ-032 SHALL recognise the macro SEQ_DET_CTRL_NONOVERLAP_EN.
REQ-033 SHALL, when SEQ_DET_CTRL_NONOVERLAP_EN is defined, clear the fill counter to 0 after each match, so bits of a reported match are never reused.
REQ-034 SHALL, when SEQ_DET_CTRL_NONOVERLAP_EN is undefined, allow overlapping matches, with the fill counter unaffected by a match.

Verification
REQ-035 SHALL cover: reset asserted, then released -> out=0, match_count=0, cfg_ready=1, busy=0; arm with the default configuration and stream 1,0,1,1 -> one out pulse after bit 4, match_count=1.
REQ-036 SHALL cover: pattern 8'h0B, cfg_len=3, stream 1,0,1,1,0,1,1 -> overlap build gives pulses after bits 4 and 7 with match_count=2, and SEQ_DET_CTRL_NONOVERLAP_EN build gives a pulse after bit 4 only with match_count=1.
REQ-037 SHALL cover: pattern 8'h03, cfg_len=1, stream 1 repeated 300 times (overlap build) -> out high on every sampling edge from bit 2 onward, match_count saturating at 255.
REQ-038 SHALL cover: in_valid gaps inserted between bits of 1,0,1,1 -> single pulse after the last valid bit, no pulse during gaps.
REQ-039 SHALL cover: cfg_valid with pattern 8'hFF while ARMED -> cfg_ready=0 and configuration unchanged; disarm and arm high together -> IDLE.
REQ-040 SHALL cover: reset pulse after bits 1,0,1 of 1011 -> no pulse and state=IDLE; re-arm and stream 1,0,1,1 -> one pulse.
